oled_cmd_sequencer: RTL and testbench

//  Queues character/bitmap/clear commands from user logic and issues them one at a time to oledDriver.

---
 rtl/oled_seq_pkg.sv | 41 ++++
 rtl/oled_cmd_fifo.sv | 50 +++++
 rtl/oled_cmd_sequencer.sv | 136 +++++++++++++
 tb/tb_oled_cmd_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_seq_pkg.sv
// Shared encodings and command-entry layout for the OLED command sequencer.
package oled_seq_pkg;

    typedef enum logic [1:0] {
        CMD_CHAR  = 2'b00,
        CMD_BMP   = 2'b01,
        CMD_CLEAR = 2'b10,
        CMD_RSVD  = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_ISSUE     = 2'b01,
        S_WAIT_BUSY = 2'b10,
        S_WAIT_DONE = 2'b11
    } state_e;

    // Fields packed as {cmd,charval,row,col,bmp}; together they need 18 bits.
    typedef struct packed {
        cmd_e       cmd;
        logic [7:0] charval;
        logic [1:0] row;
        logic [3:0] col;
        logic [1:0] bmp;
    } cmd_entry_t;

    localparam int ENTRY_W = $bits(cmd_entry_t);

    function automatic cmd_entry_t pack_entry(input logic [1:0] cmd, input logic [7:0] charval,
                                              input logic [1:0] row, input logic [3:0] col,
                                              input logic [1:0] bmp);
        cmd_entry_t e;
        e.cmd     = cmd_e'(cmd);
        e.charval = charval;
        e.row     = row;
        e.col     = col;
        e.bmp     = bmp;
        return e;
    endfunction

endpackage

// File: rtl/oled_cmd_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two so pointers wrap naturally.
module oled_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 18
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // A pop in the full cycle does not open a slot for a same-cycle push.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/oled_cmd_sequencer.sv
// Queues CHAR/BMP/CLEAR commands and issues them one at a time to oledDriver.
// Optional WAIT_DONE watchdog enabled by defining OLED_SEQ_TIMEOUT_EN.
module oled_cmd_sequencer
    import oled_seq_pkg::*;
#(
    parameter int FIFO_DEPTH    = 8,
    parameter int BUSY_WAIT_MAX = 16
`ifdef OLED_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 2**22
`endif
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [1:0]                    in_cmd,
    input  logic [7:0]                    in_charval,
    input  logic [1:0]                    in_row,
    input  logic [3:0]                    in_col,
    input  logic [1:0]                    in_bmp,
    input  logic                          drv_ready,
    output logic                          showchar,
    output logic                          showbmp,
    output logic                          clear,
    output logic [7:0]                    charval,
    output logic [1:0]                    char_row,
    output logic [3:0]                    char_col,
    output logic [1:0]                    bmp,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          err
);
    localparam int BW_W = $clog2(BUSY_WAIT_MAX + 1);

    state_e           state, state_nxt;
    cmd_entry_t       wentry, head;
    logic             fifo_full, fifo_empty;
    logic             push, pop;
    logic             stall, to_hit;
    logic [BW_W-1:0]  wb_cnt;

    assign in_ready = !fifo_full;
    // Reserved commands complete the handshake but never enter the queue.
    assign push     = in_valid && in_ready && (in_cmd != CMD_RSVD);
    assign wentry   = pack_entry(in_cmd, in_charval, in_row, in_col, in_bmp);
    assign busy     = (state != S_IDLE) || !fifo_empty;

    oled_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (wentry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef OLED_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
    logic            err_q;

    assign to_hit = (state == S_WAIT_DONE) && !drv_ready && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign stall  = err_q;
    assign err    = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            to_cnt <= (state == S_WAIT_DONE) ? to_cnt + 1'b1 : '0;
            if (to_hit) err_q <= 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
    assign stall  = 1'b0;
    assign err    = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty && drv_ready && !stall) begin
                    pop       = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE:     state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                // A driver that never acknowledges is treated as having completed.
                if (!drv_ready)                                 state_nxt = S_WAIT_DONE;
                else if (wb_cnt == BW_W'(BUSY_WAIT_MAX - 1))    state_nxt = S_IDLE;
            end
            S_WAIT_DONE: if (drv_ready || to_hit) state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wb_cnt   <= '0;
            showchar <= 1'b0;
            showbmp  <= 1'b0;
            clear    <= 1'b0;
            charval  <= '0;
            char_row <= '0;
            char_col <= '0;
            bmp      <= '0;
        end else begin
            state    <= state_nxt;
            wb_cnt   <= (state == S_WAIT_BUSY) ? wb_cnt + 1'b1 : '0;
            // Pulses are set on the pop edge so they coincide with the ISSUE cycle.
            showchar <= pop && (head.cmd == CMD_CHAR);
            showbmp  <= pop && (head.cmd == CMD_BMP);
            clear    <= pop && (head.cmd == CMD_CLEAR);
            if (pop) begin
                charval  <= head.charval;
                char_row <= head.row;
                char_col <= head.col;
                bmp      <= head.bmp;
            end
        end
    end

endmodule

// File: tb/tb_oled_cmd_sequencer.sv
// Directed bench for oled_cmd_sequencer with a simple oledDriver ready model.
module tb_oled_cmd_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_cmd = '0;
    logic [7:0] in_charval = '0;
    logic [1:0] in_row = '0;
    logic [3:0] in_col = '0;
    logic [1:0] in_bmp = '0;
    logic       drv_ready;
    logic       showchar, showbmp, clear;
    logic [7:0] charval;
    logic [1:0] char_row, bmp;
    logic [3:0] char_col;
    logic       busy, err;
    logic [3:0] fifo_count;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_push_cyc = 0;

    // driver model knobs
    int   drv_hold = 3;
    logic drv_never = 1'b0;
    logic drv_force_low = 1'b0;
    int   lo_cnt = 0;

    int         p_kind[$];
    logic [7:0] p_char[$];
    logic [1:0] p_bmp[$];
    int         p_cyc[$];

    oled_cmd_sequencer #(
        .FIFO_DEPTH     (8),
        .BUSY_WAIT_MAX  (16)
`ifdef OLED_SEQ_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (64)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cmd     (in_cmd),
        .in_charval (in_charval),
        .in_row     (in_row),
        .in_col     (in_col),
        .in_bmp     (in_bmp),
        .drv_ready  (drv_ready),
        .showchar   (showchar),
        .showbmp    (showbmp),
        .clear      (clear),
        .charval    (charval),
        .char_row   (char_row),
        .char_col   (char_col),
        .bmp        (bmp),
        .busy       (busy),
        .fifo_count (fifo_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Driver drops ready the cycle after a pulse and holds it low drv_hold cycles.
    always @(posedge clk) begin
        if (!drv_never && (showchar || showbmp || clear)) lo_cnt <= drv_hold;
        else if (lo_cnt != 0)                             lo_cnt <= lo_cnt - 1;
    end
    assign drv_ready = !drv_force_low && (lo_cnt == 0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (showchar || showbmp || clear)) begin
            chk("pulse_onehot", 32'($countones({showchar, showbmp, clear})), 32'd1);
            p_kind.push_back(showchar ? 0 : (showbmp ? 1 : 2));
            p_char.push_back(charval);
            p_bmp.push_back(bmp);
            p_cyc.push_back(cyc);
        end
    end

    task automatic clr_log();
        p_kind.delete(); p_char.delete(); p_bmp.delete(); p_cyc.delete();
    endtask

    // Starts and ends on a negedge; waits (bounded) for in_ready.
    task automatic push(input logic [1:0] c, input logic [7:0] cv, input logic [1:0] r,
                        input logic [3:0] co, input logic [1:0] b);
        int n = 0;
        in_cmd = c; in_charval = cv; in_row = r; in_col = co; in_bmp = b;
        in_valid = 1'b1;
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        if (n == 300) chk("push_ready", 32'(in_ready), 32'd1);
        last_push_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_pulses(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && p_cyc.size() < n; i++) @(negedge clk);
        chk(tag, 32'(p_cyc.size()), 32'(n));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget && (busy || !drv_ready); i++) @(negedge clk);
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int t0, bad;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_pulses", 32'({showchar, showbmp, clear}), 32'd0);
        chk("rst_operands", 32'({charval, char_row, char_col, bmp}), 32'd0);

        // 1: single CHAR 'A' at row 1, col 5
        clr_log(); drv_hold = 100;
        push(2'b00, 8'h41, 2'd1, 4'd5, 2'd0);
        t0 = last_push_cyc;
        wait_pulses("t1_npulse", 1, 10);
        if (p_cyc.size() == 1) begin
            chk("t1_latency", 32'(p_cyc[0] - t0), 32'd2);
            chk("t1_kind", 32'(p_kind[0]), 32'd0);
            chk("t1_charval", 32'(p_char[0]), 32'h41);
            bad = 0;
            for (int i = 0; i < 300 && busy; i++) begin
                if (charval != 8'h41 || char_row != 2'd1 || char_col != 4'd5) bad = 1;
                @(negedge clk);
            end
            chk("t1_operands_stable", 32'(bad), 32'd0);
            chk("t1_busy_fall", 32'(cyc - p_cyc[0]), 32'd102);
        end
        chk("t1_single_pulse", 32'(p_cyc.size()), 32'd1);

        // 2: ten CHARs against a stalled driver
        wait_idle("t2_pre_idle", 200);
        clr_log(); drv_hold = 3; drv_force_low = 1'b1;
        for (int i = 0; i < 8; i++) push(2'b00, 8'(8'h50 + i), 2'd0, 4'(i), 2'd0);
        chk("t2_count_full", 32'(fifo_count), 32'd8);
        chk("t2_in_ready_low", 32'(in_ready), 32'd0);
        drv_force_low = 1'b0;
        bad = 0;
        for (int i = 0; i < 20 && fifo_count == 4'd8; i++) begin
            if (in_ready) bad = 1;
            @(negedge clk);
        end
        chk("t2_full_no_bypass", 32'(bad), 32'd0);
        push(2'b00, 8'h58, 2'd0, 4'd8, 2'd0);
        push(2'b00, 8'h59, 2'd0, 4'd9, 2'd0);
        wait_pulses("t2_npulse", 10, 300);
        bad = 0;
        for (int i = 0; i < p_char.size(); i++)
            if (p_char[i] != 8'(8'h50 + i) || p_kind[i] != 0) bad++;
        chk("t2_order", 32'(bad), 32'd0);
        t0 = 1000;
        for (int i = 1; i < p_cyc.size(); i++)
            if (p_cyc[i] - p_cyc[i-1] < t0) t0 = p_cyc[i] - p_cyc[i-1];
        chk("t2_min_spacing", 32'(t0 >= 4), 32'd1);

        // 3: CLEAR, BMP 2, reserved, CHAR 0x30
        wait_idle("t3_pre_idle", 200);
        clr_log(); drv_force_low = 1'b1;
        push(2'b10, 8'h00, 2'd0, 4'd0, 2'd0);
        push(2'b01, 8'h00, 2'd0, 4'd0, 2'd2);
        chk("t3_count_pre_rsvd", 32'(fifo_count), 32'd2);
        push(2'b11, 8'hEE, 2'd3, 4'd15, 2'd3);
        chk("t3_rsvd_not_stored", 32'(fifo_count), 32'd2);
        push(2'b00, 8'h30, 2'd2, 4'd3, 2'd0);
        chk("t3_count_peak", 32'(fifo_count), 32'd3);
        drv_force_low = 1'b0;
        wait_pulses("t3_npulse", 3, 100);
        repeat (40) @(negedge clk);
        chk("t3_no_extra", 32'(p_cyc.size()), 32'd3);
        if (p_cyc.size() >= 3) begin
            chk("t3_kinds", 32'({p_kind[0][1:0], p_kind[1][1:0], p_kind[2][1:0]}), 32'b10_01_00);
            chk("t3_bmp", 32'(p_bmp[1]), 32'd2);
            chk("t3_char", 32'(p_char[2]), 32'h30);
        end

        // 4: driver never acknowledges
        wait_idle("t4_pre_idle", 200);
        clr_log(); drv_never = 1'b1;
        push(2'b00, 8'h11, 2'd0, 4'd0, 2'd0);
        push(2'b00, 8'h12, 2'd0, 4'd0, 2'd0);
        wait_pulses("t4_npulse", 2, 100);
        if (p_cyc.size() == 2) chk("t4_spacing", 32'(p_cyc[1] - p_cyc[0]), 32'd18);
        wait_idle("t4_idle", 100);
        chk("t4_err", 32'(err), 32'd0);
        drv_never = 1'b0;

        // 5: reset during WAIT_DONE with 3 entries queued
        clr_log(); drv_hold = 100;
        for (int i = 0; i < 4; i++) push(2'b00, 8'(8'h70 + i), 2'd0, 4'd0, 2'd0);
        wait_pulses("t5_first", 1, 20);
        repeat (5) @(negedge clk);
        chk("t5_queued", 32'(fifo_count), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_count_cleared", 32'(fifo_count), 32'd0);
        chk("t5_busy_cleared", 32'(busy), 32'd0);
        clr_log();
        repeat (150) @(negedge clk);
        chk("t5_no_pulses", 32'(p_cyc.size()), 32'd0);
        chk("t5_in_ready", 32'(in_ready), 32'd1);

        // 6: ready stuck low after a pulse
        clr_log(); drv_hold = 200;
        push(2'b00, 8'h66, 2'd0, 4'd0, 2'd0);
        wait_pulses("t6_first", 1, 20);
        repeat (100) @(negedge clk);
`ifdef OLED_SEQ_TIMEOUT_EN
        chk("t6_err_set", 32'(err), 32'd1);
        chk("t6_busy_after_to", 32'(busy), 32'd0);
        push(2'b00, 8'h67, 2'd0, 4'd0, 2'd0);
        repeat (200) @(negedge clk);
        chk("t6_no_pop", 32'(p_cyc.size()), 32'd1);
        chk("t6_count_held", 32'(fifo_count), 32'd1);
`else
        chk("t6_err_clear", 32'(err), 32'd0);
        chk("t6_still_waiting", 32'(busy), 32'd1);
        push(2'b00, 8'h67, 2'd0, 4'd0, 2'd0);
        wait_pulses("t6_second", 2, 300);
        chk("t6_err_final", 32'(err), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
